// File: rtl/dram_lsu.sv
// Load/store unit between the MEM stage and the memory read/write port: alignment check, size-masked stores,
// sign/zero-extended loads, stall and timeout. Optional counters enabled by DRAM_LSU_ACCESS_COUNT_EN.
module dram_lsu #(
    parameter int WORD_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]    req_wdata,
    output logic                    req_ready,
    output logic                    stall,
    output logic                    rsp_valid,
    output logic [WORD_SIZE-1:0]    rsp_rdata,
    output logic                    misaligned,
    output logic                    timeout_err,
    output logic                    mem_enable,
    output logic                    mem_rnw,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]    mem_wdata,
    output logic                    mem_wdata_oe,
    input  logic [WORD_SIZE-1:0]    mem_rdata,
    input  logic                    mem_ready
`ifdef DRAM_LSU_ACCESS_COUNT_EN
    ,
    output logic [31:0]             load_cnt,
    output logic [31:0]             store_cnt,
    output logic [15:0]             misalign_cnt
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           we_q;
    logic           signed_q;
    logic [1:0]     size_q;

    logic                 misal_d;
    logic [WORD_SIZE-1:0] wdata_d;
    logic [WORD_SIZE-1:0] rdata_d;

    always_comb begin
        misal_d = 1'b0;
        wdata_d = req_wdata;
        case (req_size)
            2'b00: wdata_d = {{(WORD_SIZE-8){1'b0}}, req_wdata[7:0]};
            2'b01: begin
                misal_d = req_addr[0];
                wdata_d = {{(WORD_SIZE-16){1'b0}}, req_wdata[15:0]};
            end
            default: misal_d = |req_addr[1:0];
        endcase
    end

    always_comb begin
        rdata_d = mem_rdata;
        case (size_q)
            2'b00:   rdata_d = {{(WORD_SIZE-8){signed_q & mem_rdata[7]}}, mem_rdata[7:0]};
            2'b01:   rdata_d = {{(WORD_SIZE-16){signed_q & mem_rdata[15]}}, mem_rdata[15:0]};
            default: rdata_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= '0;
            req_ready    <= 1'b1;
            stall        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            misaligned   <= 1'b0;
            timeout_err  <= 1'b0;
            mem_enable   <= 1'b0;
            mem_rnw      <= 1'b1;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wdata_oe <= 1'b0;
`ifdef DRAM_LSU_ACCESS_COUNT_EN
            load_cnt     <= '0;
            store_cnt    <= '0;
            misalign_cnt <= '0;
`endif
        end else begin
            misaligned <= 1'b0;
            rsp_valid  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (misal_d) begin
                            misaligned <= 1'b1;
`ifdef DRAM_LSU_ACCESS_COUNT_EN
                            misalign_cnt <= misalign_cnt + 16'd1;
`endif
                        end else begin
                            state_q      <= S_ACCESS;
                            cnt_q        <= CW'(1);
                            we_q         <= req_we;
                            signed_q     <= req_signed;
                            size_q       <= req_size;
                            req_ready    <= 1'b0;
                            stall        <= 1'b1;
                            mem_enable   <= 1'b1;
                            mem_rnw      <= ~req_we;
                            mem_addr     <= req_addr;
                            mem_wdata    <= req_we ? wdata_d : '0;
                            mem_wdata_oe <= req_we;
                        end
                    end
                end
                S_ACCESS: begin
                    // First ACCESS cycle ignores mem_ready: it may still be high from the last access
                    if (mem_ready && cnt_q >= CW'(2)) begin
                        state_q      <= S_RESP;
                        mem_enable   <= 1'b0;
                        mem_wdata_oe <= 1'b0;
                        mem_rnw      <= 1'b1;
                        mem_wdata    <= '0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= we_q ? '0 : rdata_d;
`ifdef DRAM_LSU_ACCESS_COUNT_EN
                        if (we_q) store_cnt <= store_cnt + 32'd1;
                        else      load_cnt  <= load_cnt + 32'd1;
`endif
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                        state_q      <= S_RESP;
                        mem_enable   <= 1'b0;
                        mem_wdata_oe <= 1'b0;
                        mem_rnw      <= 1'b1;
                        mem_wdata    <= '0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                        timeout_err  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    state_q   <= S_IDLE;
                    stall     <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dram_lsu.md
Name: dram_lsu

Overview:
- Load/store unit between the DLX MEM stage and the data read/write memory port (mem_interface.rw side).
- Accepts one load/store request at a time and checks alignment.
- Drives ENABLE/READNOTWRITE/ADDRESS/write data and waits on DATA_READY. Loads are size-masked and sign/zero-extended.
- Raises a pipeline stall while an access is outstanding and flags timeouts.

Parameters:
- WORD_SIZE, 32, data width in bits
- ADDRESS_SIZE, 16, address width in bits, matching the memory
- TIMEOUT_CYCLES, 15, maximum ACCESS cycles without mem_ready before abort (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM-stage access request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word; 11 is treated as word
- req_signed  in  1  1=sign-extend load, 0=zero-extend
- req_addr  in  ADDRESS_SIZE  byte address
- req_wdata  in  WORD_SIZE  store data
- req_ready  out  1  high only in IDLE
- stall  out  1  high from the cycle after acceptance until the RESP cycle inclusive
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  WORD_SIZE  extended load data (0 for stores/timeouts)
- misaligned  out  1  one-cycle pulse, request rejected
- timeout_err  out  1  sticky error flag
- mem_enable  out  1  to ENABLE
- mem_rnw  out  1  to READNOTWRITE
- mem_addr  out  ADDRESS_SIZE  to ADDRESS
- mem_wdata  out  WORD_SIZE  store data
- mem_wdata_oe  out  1  high = wrapper drives INOUT_DATA with mem_wdata, else 'Z
- mem_rdata  in  WORD_SIZE  INOUT_DATA sampled
- mem_ready  in  1  DATA_READY

Behaviour:
- Reset (async, rst=0): FSM=IDLE. All outputs 0 except req_ready=1 and mem_rnw=1. Counters cleared. Reset mid-access drops mem_enable immediately; no rsp_valid is produced.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- Acceptance: req_valid && req_ready at edge N.
  - Aligned request: latch addr/we/size/signed/wdata and go to ACCESS.
  - Alignment rule: half needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned.
  - Misaligned request: stay in IDLE, pulse misaligned during cycle N+1, no memory access, no rsp_valid.
- ACCESS state:
  - mem_enable=1, mem_rnw=~we, mem_addr=latched addr.
  - For stores: mem_wdata = wdata masked to size (bits above 8/16 zeroed) and mem_wdata_oe=1.
  - Wait counter starts at 1 on entry and increments each cycle.
  - mem_ready is ignored in the first ACCESS cycle, because the memory's ready flag can be stale from the previous access.
  - mem_ready=1 sampled with counter>=2: capture mem_rdata and go to RESP.
  - Counter reaching TIMEOUT_CYCLES without a qualified mem_ready: go to RESP with rdata=0 and set timeout_err. timeout_err stays set until reset.
- RESP state (one cycle): mem_enable=0, mem_wdata_oe=0, rsp_valid=1, stall=1; then return to IDLE.
  - mem_enable is therefore low for at least one cycle between accesses.
- Best-case latency: accept at N, ACCESS N+1..N+2, rsp_valid at N+3.
- Load extension:
  - byte: rdata[7:0], extended from bit 7.
  - half: rdata[15:0], extended from bit 15.
  - word: passed through unchanged.
  - Sign vs zero extension selected by req_signed.
- A store returns rsp_valid with rsp_rdata=0.
- req_valid while not in IDLE is ignored; the pipeline must hold its request while stall=1.

Optional Feature:
- Macro: DRAM_LSU_ACCESS_COUNT_EN.
- With the macro defined:
  - Extra outputs load_cnt[31:0], store_cnt[31:0] and misalign_cnt[15:0].
  - load_cnt/store_cnt increment on each RESP of a non-timed-out load/store.
  - misalign_cnt increments on each misaligned pulse.
  - All three wrap modulo width and clear on reset.
- Without the macro: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Word load: memory holds 0x8000_00F0 at 0x0010; memory asserts ready 2 cycles after enable; load word at 0x0010 -> one rsp_valid, rsp_rdata=0x8000_00F0, stall high for exactly 3 cycles.
- Byte signed vs unsigned: mem_rdata=0x0000_00F0 -> signed byte load gives 0xFFFF_FFF0, unsigned gives 0x0000_00F0. Half at 0x0002 with mem_rdata=0x0000_8001, signed -> 0xFFFF_8001.
- Store half 0xDEAD_BEEF at 0x0004 -> mem_rnw=0, mem_wdata_oe=1, mem_wdata=0x0000_BEEF while mem_enable=1; rsp_rdata=0.
- Misaligned word at 0x0006 -> misaligned pulses 1 cycle, mem_enable never asserted, req_ready stays 1. Under DRAM_LSU_ACCESS_COUNT_EN, misalign_cnt=1.
- Timeout: hold mem_ready=0 with TIMEOUT_CYCLES=15 -> mem_enable high 15 cycles, rsp_valid with rdata=0, timeout_err=1 and still 1 after a following successful load.
- Reset mid-ACCESS: drop rst in the second ACCESS cycle -> mem_enable=0 with no clock edge, no rsp_valid; req_ready=1 after release.
